// File: rtl/vc_buffer.sv
// vc_buffer: NUM_VC independent circular FIFOs behind one write and one read port.
// Per-VC occupancy flags feed credit return; sticky flags record protocol misuse.
module vc_buffer #(
  parameter  int WIDTH     = 64,
  parameter  int DEPTH     = 8,
  parameter  int NUM_VC    = 4,
  parameter  int AF_THRESH = DEPTH - 2,
  localparam int VW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [VW-1:0]        in_vc,
  input  logic                 produce,
  input  logic [VW-1:0]        out_vc,
  input  logic                 consume,
  output logic [WIDTH-1:0]     out_data,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] usedw,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clear_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem   [NUM_VC][DEPTH];
  logic [AW-1:0]    r_head  [NUM_VC];
  logic [AW-1:0]    r_tail  [NUM_VC];
  logic [CW-1:0]    r_count [NUM_VC];
  logic             r_ovf;
  logic             r_udf;

  logic              w_in_ok;
  logic              w_out_ok;
  logic              w_wr_full;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [NUM_VC-1:0] w_inc;
  logic [NUM_VC-1:0] w_dec;

  assign w_in_ok   = int'(in_vc) < NUM_VC;
  assign w_out_ok  = int'(out_vc) < NUM_VC;
  assign w_wr_full = w_in_ok && (r_count[in_vc] == CW'(DEPTH));
  assign w_rd_ok   = consume && w_out_ok
                  && (r_count[out_vc] != '0);
  // A full VC still takes a write when it is being popped this cycle.
  assign w_wr_ok   = produce && w_in_ok
                  && (!w_wr_full || (consume && out_vc == in_vc));

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_inc[v] = w_wr_ok && (in_vc == VW'(v));
      w_dec[v] = w_rd_ok && (out_vc == VW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_head[v]  <= '0;
        r_tail[v]  <= '0;
        r_count[v] <= '0;
      end
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_inc[v])
          r_tail[v] <= r_tail[v] + AW'(1);
        if (w_dec[v])
          r_head[v] <= r_head[v] + AW'(1);
        unique case ({w_inc[v], w_dec[v]})
          2'b10:   r_count[v] <= r_count[v] + CW'(1);
          2'b01:   r_count[v] <= r_count[v] - CW'(1);
          default: r_count[v] <= r_count[v];
        endcase
      end
      r_ovf <= (r_ovf & ~clear_err) | (produce & ~w_wr_ok);
      r_udf <= (r_udf & ~clear_err) | (consume & ~w_rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok)
      r_mem[in_vc][r_tail[in_vc]] <= in_data;
  end

  always_comb begin
    full        = '0;
    empty       = '0;
    almost_full = '0;
    usedw       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]             = r_count[v] == CW'(DEPTH);
      empty[v]            = r_count[v] == '0;
      almost_full[v]      = r_count[v] >= CW'(AF_THRESH);
      usedw[v*CW +: CW]   = r_count[v];
    end
  end

  always_comb begin
    out_data = '0;
    if (w_out_ok && r_count[out_vc] != '0)
      out_data = r_mem[out_vc][r_head[out_vc]];
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: directed vector table plus hand sequences and a
// queue scoreboard for random multi-VC traffic.
module tb_vc_buffer;

  localparam int W  = 64;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [1:0]    in_vc;
  logic          produce;
  logic [1:0]    out_vc;
  logic          consume;
  logic [W-1:0]  out_data;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic [N-1:0]  almost_full;
  logic [N*CW-1:0] usedw;
  logic          overflow;
  logic          underflow;
  logic          clear_err;

  vc_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_vc(in_vc), .produce(produce),
    .out_vc(out_vc), .consume(consume), .out_data(out_data),
    .full(full), .empty(empty), .almost_full(almost_full),
    .usedw(usedw), .overflow(overflow), .underflow(underflow),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        prod;
    logic [63:0] din;
    logic        cons;
    logic        clr;
    logic [63:0] e_data;
    logic [3:0]  e_empty;
    logic [3:0]  e_full;
    logic [3:0]  e_af;
    logic [3:0]  e_cnt;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t tv[$];
  logic [63:0] q[N][$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    produce   = 1'b0;
    consume   = 1'b0;
    clear_err = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int v);
    return usedw[v*CW +: CW];
  endfunction

  function automatic vec_t mk(
    input logic p, input logic [63:0] d, input logic c, input logic cl,
    input logic [63:0] ed, input logic [3:0] em, input logic [3:0] fu,
    input logic [3:0] af, input logic [3:0] cn, input logic ov,
    input logic ud);
    vec_t r;
    r.prod = p;   r.din = d;     r.cons = c;   r.clr = cl;
    r.e_data = ed; r.e_empty = em; r.e_full = fu; r.e_af = af;
    r.e_cnt = cn; r.e_ovf = ov;  r.e_udf = ud;
    return r;
  endfunction

  initial begin
    in_data = '0;
    in_vc   = '0;
    out_vc  = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_data", out_data, 0);

    // Fill VC2 with 0x11..0x18, overflow, clear, drain, underflow.
    for (int k = 1; k <= 8; k++)
      tv.push_back(mk(1, 64'h10 + 64'(k), 0, 0, 64'h11, 4'b1011,
                      (k == 8) ? 4'b0100 : 4'b0000,
                      (k >= 6) ? 4'b0100 : 4'b0000, 4'(k), 0, 0));
    tv.push_back(mk(1, 64'h99, 0, 0, 64'h11, 4'b1011, 4'b0100,
                    4'b0100, 4'd8, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 64'h11, 4'b1011, 4'b0100,
                    4'b0100, 4'd8, 0, 0));
    for (int j = 1; j <= 8; j++)
      tv.push_back(mk(0, 0, 1, 0,
                      (j < 8) ? 64'h11 + 64'(j) : 64'h0,
                      (j == 8) ? 4'b1111 : 4'b1011, 4'b0000,
                      (8 - j >= 6) ? 4'b0100 : 4'b0000,
                      4'(8 - j), 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 4'b1111, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 1, 0, 4'b1111, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 0, 0, 0, 0, 0));

    in_vc  = 2'd2;
    out_vc = 2'd2;
    for (int i = 0; i < tv.size(); i++) begin
      produce   = tv[i].prod;
      in_data   = tv[i].din;
      consume   = tv[i].cons;
      clear_err = tv[i].clr;
      tick();
      chk($sformatf("v%0d_data", i), out_data, tv[i].e_data);
      chk($sformatf("v%0d_empty", i), empty, tv[i].e_empty);
      chk($sformatf("v%0d_full", i), full, tv[i].e_full);
      chk($sformatf("v%0d_af", i), almost_full, tv[i].e_af);
      chk($sformatf("v%0d_cnt", i), cnt(2), tv[i].e_cnt);
      chk($sformatf("v%0d_ovf", i), overflow, tv[i].e_ovf);
      chk($sformatf("v%0d_udf", i), underflow, tv[i].e_udf);
    end
    idle();

    // Full VC2: simultaneous write and pop is not an overflow.
    in_vc  = 2'd2;
    out_vc = 2'd2;
    for (int k = 0; k < 8; k++) begin
      produce = 1'b1;
      in_data = 64'h11 + 64'(k);
      tick();
    end
    produce = 1'b1;
    consume = 1'b1;
    in_data = 64'hAA;
    #1;
    chk("sim_head", out_data, 64'h11);
    tick();
    idle();
    chk("sim_cnt", cnt(2), 8);
    chk("sim_full", full[2], 1);
    chk("sim_ovf", overflow, 0);
    chk("sim_next", out_data, 64'h12);
    for (int k = 0; k < 8; k++) begin
      consume = 1'b1;
      #1;
      chk($sformatf("sim_pop%0d", k), out_data,
          (k < 7) ? 64'h12 + 64'(k) : 64'hAA);
      tick();
      consume = 1'b0;
    end
    chk("sim_empty", empty[2], 1);

    // Random writes on VC0/VC3 against pops on VC1.
    do_reset();
    in_vc = 2'd1;
    for (int k = 0; k < 5; k++) begin
      produce = 1'b1;
      in_data = 64'h500 + 64'(k);
      q[1].push_back(in_data);
      tick();
    end
    idle();
    for (int c = 0; c < 100; c++) begin
      logic       pw;
      logic       pc;
      logic [1:0] wv;
      logic [63:0] dat;
      pw  = 1'($urandom_range(0, 1));
      wv  = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
      dat = {$urandom, $urandom};
      pc  = ($urandom_range(0, 2) == 0);
      produce = pw;
      in_vc   = wv;
      in_data = dat;
      consume = pc;
      out_vc  = 2'd1;
      #1;
      chk($sformatf("rnd%0d_head", c), out_data,
          (q[1].size() > 0) ? q[1][0] : 64'h0);
      if (pw && q[wv].size() < D)
        q[wv].push_back(dat);
      if (pc && q[1].size() > 0)
        void'(q[1].pop_front());
      tick();
      for (int v = 0; v < N; v++)
        chk($sformatf("rnd%0d_cnt%0d", c, v), cnt(v), q[v].size());
    end
    idle();
    for (int v = 0; v < N; v += 3) begin
      out_vc = 2'(v);
      while (q[v].size() > 0) begin
        consume = 1'b1;
        #1;
        chk($sformatf("drain%0d", v), out_data, q[v][0]);
        void'(q[v].pop_front());
        tick();
      end
      consume = 1'b0;
      chk($sformatf("drain%0d_empty", v), empty[v], 1);
    end

    // Sustained write+pop on VC1 across several pointer wraps.
    do_reset();
    in_vc   = 2'd1;
    out_vc  = 2'd1;
    produce = 1'b1;
    in_data = 64'h100;
    tick();
    for (int i = 0; i < 3 * D; i++) begin
      produce = 1'b1;
      consume = 1'b1;
      in_data = 64'h101 + 64'(i);
      #1;
      chk($sformatf("wrap%0d_data", i), out_data, 64'h100 + 64'(i));
      tick();
      chk($sformatf("wrap%0d_cnt", i), cnt(1), 1);
    end
    produce = 1'b0;
    consume = 1'b1;
    #1;
    chk("wrap_last", out_data, 64'h100 + 64'(3 * D));
    tick();
    idle();
    chk("wrap_empty", empty[1], 1);
    chk("wrap_ovf", overflow, 0);
    chk("wrap_udf", underflow, 0);

    // Reset with every VC partly full and traffic active.
    do_reset();
    out_vc  = 2'd0;
    consume = 1'b1;
    tick();
    idle();
    for (int v = 0; v < N; v++)
      for (int k = 0; k < 3; k++) begin
        produce = 1'b1;
        in_vc   = 2'(v);
        in_data = 64'h700 + 64'(v * 16 + k);
        tick();
      end
    idle();
    chk("pre_rst_udf", underflow, 1);
    chk("pre_rst_data", out_data, 64'h700);
    rst     = 1'b1;
    produce = 1'b1;
    consume = 1'b1;
    in_vc   = 2'd0;
    out_vc  = 2'd0;
    tick();
    idle();
    chk("mrst_empty", empty, 4'hF);
    chk("mrst_usedw", usedw, 0);
    chk("mrst_full", full, 0);
    chk("mrst_af", almost_full, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_udf", underflow, 0);
    chk("mrst_data", out_data, 0);
    tick();
    chk("mrst_hold", usedw, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
